// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - request/result bundle between the EX stage and the multiply/divide unit
interface muldiv_unit_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic                  start;
    logic                  cancel;
    logic [1:0]            operator;
    logic [DATA_WIDTH-1:0] operand1;
    logic [DATA_WIDTH-1:0] operand2;
    logic                  busy;
    logic                  stall_request;
    logic                  result_valid;
    logic [DATA_WIDTH-1:0] result_hi;
    logic [DATA_WIDTH-1:0] result_lo;
    logic                  div_by_zero;

    modport master (
        output start, cancel, operator, operand1, operand2,
        input  busy, stall_request, result_valid, result_hi, result_lo, div_by_zero
    );

    modport slave (
        input  start, cancel, operator, operand1, operand2,
        output busy, stall_request, result_valid, result_hi, result_lo, div_by_zero
    );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit returning a {hi, lo} pair
// One bit per cycle on magnitudes; signs are restored in a single FIX cycle.
module muldiv_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic           clock,
    input  logic           reset,
    muldiv_unit_if.slave   bus
);
    localparam int W           = DATA_WIDTH;
    localparam int COUNT_WIDTH = $clog2(DATA_WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b10;

    logic [1:0]             state_q, state_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [1:0]             op_q, op_d;
    logic                   sign1_q, sign1_d;
    logic                   sign2_q, sign2_d;
    logic [W-1:0]           mcand_q, mcand_d;
    logic [2*W-1:0]         acc_q, acc_d;
    logic [W-1:0]           res_hi_q, res_hi_d;
    logic [W-1:0]           res_lo_q, res_lo_d;
    logic                   dbz_q, dbz_d;

    logic [W-1:0] abs1, abs2;
    logic [W:0]   mul_sum;
    logic [W:0]   div_part;
    logic [W:0]   div_diff;
    logic [2*W-1:0] prod_fixed;
    logic [W-1:0] quo_fixed, rem_fixed;

    // Only the signed ops take magnitudes; the most-negative value maps onto itself, which is the right unsigned magnitude.
    assign abs1 = (!bus.operator[0] && bus.operand1[W-1]) ? -bus.operand1 : bus.operand1;
    assign abs2 = (!bus.operator[0] && bus.operand2[W-1]) ? -bus.operand2 : bus.operand2;

    // acc holds {partial product, multiplier} for multiply and {remainder, dividend/quotient} for divide.
    assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, mcand_q} : {(W+1){1'b0}});
    assign div_part = {acc_q[2*W-1:W], acc_q[W-1]};
    assign div_diff = div_part - {1'b0, mcand_q};

    assign prod_fixed = (op_q == OP_MULT && (sign1_q ^ sign2_q)) ? -acc_q : acc_q;
    assign quo_fixed  = (op_q == OP_DIV && (sign1_q ^ sign2_q)) ? -acc_q[W-1:0] : acc_q[W-1:0];
    assign rem_fixed  = (op_q == OP_DIV && sign1_q) ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        sign1_d  = sign1_q;
        sign2_d  = sign2_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        dbz_d    = dbz_q;
        if (state_q != S_IDLE && bus.cancel) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start && !bus.cancel) begin
                        op_d    = bus.operator;
                        sign1_d = bus.operand1[W-1];
                        sign2_d = bus.operand2[W-1];
                        if (bus.operator[1] && bus.operand2 == '0) begin
                            state_d  = S_DONE;
                            res_lo_d = '1;
                            res_hi_d = bus.operand1;
                            dbz_d    = 1'b1;
                        end else begin
                            state_d = S_CALC;
                            cnt_d   = COUNT_WIDTH'(W);
                            mcand_d = abs2;
                            acc_d   = {{W{1'b0}}, abs1};
                            dbz_d   = 1'b0;
                        end
                    end
                end
                S_CALC: begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == COUNT_WIDTH'(1)) begin
                        state_d = S_FIX;
                    end
                    if (op_q[1]) begin
                        if (div_part[W] || !div_diff[W]) begin
                            acc_d = {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
                        end else begin
                            acc_d = {div_part[W-1:0], acc_q[W-2:0], 1'b0};
                        end
                    end else begin
                        acc_d = {mul_sum, acc_q[W-1:1]};
                    end
                end
                S_FIX: begin
                    state_d = S_DONE;
                    if (op_q[1]) begin
                        res_hi_d = rem_fixed;
                        res_lo_d = quo_fixed;
                    end else begin
                        res_hi_d = prod_fixed[2*W-1:W];
                        res_lo_d = prod_fixed[W-1:0];
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            sign1_q  <= 1'b0;
            sign2_q  <= 1'b0;
            mcand_q  <= '0;
            acc_q    <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            sign1_q  <= sign1_d;
            sign2_q  <= sign2_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            dbz_q    <= dbz_d;
        end
    end

    assign bus.busy          = (state_q != S_IDLE);
    assign bus.stall_request = (state_q == S_IDLE && bus.start && !bus.cancel)
                             || state_q == S_CALC || state_q == S_FIX;
    assign bus.result_valid  = (state_q == S_DONE) && !bus.cancel;
    assign bus.div_by_zero   = (state_q == S_DONE) && !bus.cancel && dbz_q;
    assign bus.result_hi     = res_hi_q;
    assign bus.result_lo     = res_lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed bench for muldiv_unit at DATA_WIDTH 32 and 8
module tb_muldiv_unit;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic rst32;
    logic rst8;

    muldiv_unit_if #(.DATA_WIDTH(32)) b32 ();
    muldiv_unit_if #(.DATA_WIDTH(8))  b8 ();

    muldiv_unit #(.DATA_WIDTH(32)) u32 (.clock(clock), .reset(rst32), .bus(b32.slave));
    muldiv_unit #(.DATA_WIDTH(8))  u8  (.clock(clock), .reset(rst8),  .bus(b8.slave));

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #2;
    endtask

    // Start in cycle 0, then follow the op until result_valid or a 60-cycle budget runs out.
    task automatic op32(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input logic edbz, input int elat, input bit poke);
        int lat;
        lat = -1;
        b32.start    = 1'b1;
        b32.operator = op;
        b32.operand1 = a;
        b32.operand2 = b;
        #1;
        check({tag, " stall_c0"}, 64'(b32.stall_request), 64'(1));
        check({tag, " busy_c0"}, 64'(b32.busy), 64'(0));
        for (int c = 1; c <= 60 && lat < 0; c++) begin
            tick;
            b32.start = poke && (c >= 2) && (c <= 4);
            if (poke) begin
                b32.operator = 2'b11;
                b32.operand2 = 32'd0;
            end
            #1;
            if (b32.result_valid) begin
                lat = c;
                check({tag, " hi"}, 64'(b32.result_hi), 64'(ehi));
                check({tag, " lo"}, 64'(b32.result_lo), 64'(elo));
                check({tag, " dbz"}, 64'(b32.div_by_zero), 64'(edbz));
                check({tag, " busy_done"}, 64'(b32.busy), 64'(1));
                check({tag, " stall_done"}, 64'(b32.stall_request), 64'(0));
            end else begin
                check({tag, " busy_calc"}, 64'(b32.busy), 64'(1));
            end
        end
        check({tag, " latency"}, 64'(lat), 64'(elat));
        b32.start = 1'b0;
        tick;
        #1;
        check({tag, " busy_after"}, 64'(b32.busy), 64'(0));
        check({tag, " valid_after"}, 64'(b32.result_valid), 64'(0));
    endtask

    initial begin
        int seen;
        int lat8;
        rst32 = 1'b1;
        rst8  = 1'b1;
        b32.start = 1'b0; b32.cancel = 1'b0; b32.operator = 2'b00;
        b32.operand1 = '0; b32.operand2 = '0;
        b8.start = 1'b0; b8.cancel = 1'b0; b8.operator = 2'b00;
        b8.operand1 = '0; b8.operand2 = '0;
        tick;
        tick;
        #1;
        check("rst busy", 64'(b32.busy), 64'(0));
        check("rst valid", 64'(b32.result_valid), 64'(0));
        check("rst dbz", 64'(b32.div_by_zero), 64'(0));
        check("rst hi", 64'(b32.result_hi), 64'(0));
        check("rst lo", 64'(b32.result_lo), 64'(0));
        check("rst stall", 64'(b32.stall_request), 64'(0));
        rst32 = 1'b0;
        rst8  = 1'b0;
        tick;

        op32("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 34, 1'b0);
        op32("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34, 1'b0);
        op32("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34, 1'b0);
        op32("divu_zero", 2'b11, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1, 1, 1'b0);
        op32("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 34, 1'b0);
        op32("divu_big", 2'b11, 32'd1000, 32'd7, 32'd6, 32'd142, 1'b0, 34, 1'b0);
        op32("div_negdiv", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 34, 1'b0);

        // start together with cancel in IDLE is dropped
        b32.start = 1'b1; b32.cancel = 1'b1; b32.operator = 2'b01;
        b32.operand1 = 32'd3; b32.operand2 = 32'd3;
        #1;
        check("startcancel stall", 64'(b32.stall_request), 64'(0));
        tick;
        b32.start = 1'b0; b32.cancel = 1'b0;
        #1;
        check("startcancel busy", 64'(b32.busy), 64'(0));

        // cancel in cycle 10 of a DIVU
        b32.start = 1'b1; b32.operator = 2'b11;
        b32.operand1 = 32'd1000; b32.operand2 = 32'd7;
        tick;
        b32.start = 1'b0;
        for (int c = 2; c <= 10; c++) tick;
        b32.cancel = 1'b1;
        #1;
        check("cancel c10 busy", 64'(b32.busy), 64'(1));
        check("cancel c10 valid", 64'(b32.result_valid), 64'(0));
        tick;
        b32.cancel = 1'b0;
        #1;
        check("cancel c11 busy", 64'(b32.busy), 64'(0));
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            tick;
            #1;
            if (b32.result_valid) seen++;
        end
        check("cancel no_valid", 64'(seen), 64'(0));
        check("cancel hi_kept", 64'(b32.result_hi), 64'(32'h0000_0001));
        check("cancel lo_kept", 64'(b32.result_lo), 64'(32'hFFFF_FFFD));

        // cancel in the DONE cycle of a divide-by-zero suppresses both pulses
        b32.start = 1'b1; b32.operator = 2'b11;
        b32.operand1 = 32'd5; b32.operand2 = 32'd0;
        tick;
        b32.start = 1'b0; b32.cancel = 1'b1;
        #1;
        check("cancel_done valid", 64'(b32.result_valid), 64'(0));
        check("cancel_done dbz", 64'(b32.div_by_zero), 64'(0));
        tick;
        b32.cancel = 1'b0;
        #1;
        check("cancel_done busy", 64'(b32.busy), 64'(0));

        // reset in cycle 20 of a MULT
        b32.start = 1'b1; b32.operator = 2'b00;
        b32.operand1 = 32'hFFFF_FFFD; b32.operand2 = 32'd7;
        tick;
        b32.start = 1'b0;
        for (int c = 2; c <= 20; c++) tick;
        rst32 = 1'b1;
        tick;
        rst32 = 1'b0;
        #1;
        check("midreset busy", 64'(b32.busy), 64'(0));
        check("midreset valid", 64'(b32.result_valid), 64'(0));
        check("midreset dbz", 64'(b32.div_by_zero), 64'(0));
        check("midreset hi", 64'(b32.result_hi), 64'(0));
        check("midreset lo", 64'(b32.result_lo), 64'(0));
        check("midreset stall", 64'(b32.stall_request), 64'(0));

        op32("multu_5x6_poke", 2'b01, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0, 34, 1'b1);

        // W=8 MULTU 0xFF x 0xFF
        lat8 = -1;
        b8.start = 1'b1; b8.operator = 2'b01;
        b8.operand1 = 8'hFF; b8.operand2 = 8'hFF;
        for (int c = 1; c <= 30 && lat8 < 0; c++) begin
            tick;
            b8.start = 1'b0;
            #1;
            if (b8.result_valid) begin
                lat8 = c;
                check("w8 hi", 64'(b8.result_hi), 64'(8'hFE));
                check("w8 lo", 64'(b8.result_lo), 64'(8'h01));
            end
        end
        check("w8 latency", 64'(lat8), 64'(10));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
